// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_pkg                                             |
// | Description : Shared types and constants for the UART receiver:    |
// |               receiver state encoding and parity-mode selectors.   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_rx_sync                                         |
// | Description : Two-flop synchronizer for the asynchronous serial    |
// |               line. Flops reset to 1 so the line reads as idle.    |
// | Ports       : clk  - receive clock                                 |
// |               rst  - asynchronous reset, active low                |
// |               din  - asynchronous serial input                     |
// |               dout - synchronized serial line                      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
    end
  end

  assign dout = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_rx_core                                         |
// | Description : UART receiver with optional parity, 1 or 2 stop      |
// |               bits and a single-word valid/ready output buffer.    |
// | Ports       : clk         - receive clock, rising edge             |
// |               rst         - asynchronous reset, active low         |
// |               uart_rx     - serial line, idle high                 |
// |               data_out    - received word (LSB first on the wire)  |
// |               data_valid  - data_out holds an unconsumed word      |
// |               data_ready  - consumer accepts word when valid&ready |
// |               parity_err  - parity mismatch on word in data_out    |
// |               frame_err   - a stop bit of the word sampled low     |
// |               overrun_err - 1-cycle pulse, completed frame dropped |
// |               busy        - receiver is not idle                   |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam logic [15:0] c_HALF      = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] c_FULL      = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  c_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  c_LAST_STOP = 4'(STOP_BITS - 1);

  logic                 w_rx_s;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [15:0]          r_clk_count;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_low;
  logic                 w_tick;
  logic                 w_done;
  logic                 w_par_xor;
  logic                 w_par_err;
  logic                 w_frame_err;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (uart_rx),
    .dout (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // w_tick marks a sample point: half-bit in START, full bit elsewhere.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_clk_count == c_HALF) begin
          w_tick      = 1'b1;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_count == c_FULL) begin
          w_tick = 1'b1;
          if (r_bit_idx == c_LAST_DATA)
            w_state_nxt = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (r_clk_count == c_FULL) begin
          w_tick      = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_clk_count == c_FULL) begin
          w_tick = 1'b1;
          if (r_bit_idx == c_LAST_STOP) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit index restarts on every state change, so it counts data bits in
  // DATA and stop bits in STOP without a second counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_count <= 16'd0;
      r_bit_idx   <= 4'd0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_stop_low  <= 1'b0;
    end else begin
      if (r_state == IDLE || w_tick) r_clk_count <= 16'd0;
      else                           r_clk_count <= r_clk_count + 16'd1;

      if (w_state_nxt != r_state) r_bit_idx <= 4'd0;
      else if (w_tick)            r_bit_idx <= r_bit_idx + 4'd1;

      if (r_state == DATA && w_tick)
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

      if (r_state == PARITY && w_tick)
        r_par_bit <= w_rx_s;

      if (r_state == START)
        r_stop_low <= 1'b0;
      else if (r_state == STOP && w_tick && !w_rx_s)
        r_stop_low <= 1'b1;
    end
  end

  assign w_par_xor   = ^{r_shift, r_par_bit};
  assign w_par_err   = (PARITY_MODE == PARITY_EVEN) ? w_par_xor  :
                       (PARITY_MODE == PARITY_ODD)  ? ~w_par_xor : 1'b0;
  // The final stop sample is still on the line in the completion cycle.
  assign w_frame_err = r_stop_low | ~w_rx_s;

  // Output buffer: a completing frame is only taken when the slot is empty
  // or being drained on the same edge; otherwise the new frame is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (w_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= r_shift;
          parity_err <= w_par_err;
          frame_err  <= w_frame_err;
          data_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_uart_rx_core                                      |
// | Description : Directed scoreboard bench for uart_rx_core. Three    |
// |               instances: plain 8N1, even parity, two stop bits.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_uart_rx_core;

  localparam int c_CPB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx   [3];
  logic       rdy  [3];
  logic [7:0] dout [3];
  logic       dv   [3];
  logic       pe   [3];
  logic       fe   [3];
  logic       ov   [3];
  logic       bz   [3];

  exp_t sb[$];
  int   n_checks;
  int   n_err;

  uart_rx_core #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx[0]), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun_err(ov[0]), .busy(bz[0]));

  uart_rx_core #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .uart_rx(rx[1]), .data_out(dout[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun_err(ov[1]), .busy(bz[1]));

  uart_rx_core #(.CLKS_PER_BIT(c_CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .uart_rx(rx[2]), .data_out(dout[2]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun_err(ov[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame: start, 8 data bits LSB first, optional parity, stop(s), idle gap.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop2);
    @(negedge clk);
    rx[sel] = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[sel] = d[i];
      repeat (c_CPB) @(negedge clk);
    end
    if (use_par) begin
      rx[sel] = pbit;
      repeat (c_CPB) @(negedge clk);
    end
    rx[sel] = 1'b1;
    repeat (c_CPB) @(negedge clk);
    if (sel == 2) begin
      rx[sel] = stop2;
      repeat (c_CPB) @(negedge clk);
    end
    rx[sel] = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic wait_dv(input int sel, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dv[sel]) seen = 1'b1;
    end
  endtask

  task automatic check_word(input int sel, input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(dout[sel]), 32'(e.d));
      chk({tag, "_perr"}, 32'(pe[sel]),   32'(e.pe));
      chk({tag, "_ferr"}, 32'(fe[sel]),   32'(e.fe));
    end
  endtask

  task automatic recv(input int sel, input logic [7:0] d, input bit use_par,
                      input logic pbit, input logic stop2, input string tag);
    bit seen;
    exp_t e;
    e.d  = d;
    e.pe = use_par ? (^d ^ pbit) : 1'b0;
    e.fe = (sel == 2) ? ~stop2 : 1'b0;
    sb.push_back(e);
    fork
      send_frame(sel, d, use_par, pbit, stop2);
      begin
        wait_dv(sel, seen);
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
          check_word(sel, tag);
          chk({tag, "_ov"}, 32'(ov[sel]), 32'd0);
        end
      end
    join
  endtask

  initial begin
    bit seen;
    bit saw_dv;
    exp_t e;
    logic [7:0] d;
    n_checks = 0;
    n_err    = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bz[0]),   32'd0);
    chk("rst_valid", 32'(dv[0]),   32'd0);
    chk("rst_data",  32'(dout[0]), 32'd0);
    chk("rst_perr",  32'(pe[0]),   32'd0);
    chk("rst_ferr",  32'(fe[0]),   32'd0);
    chk("rst_ov",    32'(ov[0]),   32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Plain frame, valid for exactly one cycle with ready held high
    recv(0, 8'hA5, 1'b0, 1'b0, 1'b1, "a5");
    // recv returns well after the pulse; re-run the one-cycle check inline
    e.d = 8'h3C; e.pe = 1'b0; e.fe = 1'b0;
    sb.push_back(e);
    fork
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      begin
        wait_dv(0, seen);
        chk("3c_seen", 32'(seen), 32'd1);
        if (seen) begin
          check_word(0, "3c");
          @(negedge clk);
          chk("3c_valid_1clk", 32'(dv[0]), 32'd0);
        end
      end
    join

    // Start-bit glitch of 4 clocks: false start, no output
    @(negedge clk);
    rx[0] = 1'b0;
    saw_dv = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", 32'(bz[0]), 32'd1);
    rx[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dv[0]) saw_dv = 1'b1;
    end
    chk("glitch_no_valid", 32'(saw_dv), 32'd0);
    chk("glitch_idle",     32'(bz[0]),  32'd0);

    // Even parity: bad then good parity bit
    recv(1, 8'h03, 1'b1, 1'b1, 1'b1, "par_bad");
    recv(1, 8'h03, 1'b1, 1'b0, 1'b1, "par_good");
    recv(1, 8'h07, 1'b1, 1'b1, 1'b1, "par_odd_cnt");

    // Two stop bits: second low then both high
    recv(2, 8'h5A, 1'b0, 1'b0, 1'b0, "stop2_low");
    repeat (24) @(negedge clk);
    recv(2, 8'h5A, 1'b0, 1'b0, 1'b1, "stop2_ok");

    // Overrun: hold ready low, 0x11 kept, 0x22 dropped
    rdy[0] = 1'b0;
    recv(0, 8'h11, 1'b0, 1'b0, 1'b1, "ovr_first");
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
      begin
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (ov[0]) seen = 1'b1;
        end
        chk("ovr_pulse", 32'(seen), 32'd1);
        chk("ovr_hold_data",  32'(dout[0]), 32'h11);
        chk("ovr_hold_valid", 32'(dv[0]),   32'd1);
        @(negedge clk);
        chk("ovr_pulse_1clk", 32'(ov[0]),   32'd0);
      end
    join

    // Ready raised only on the completion edge of 0x33: sync (2) + detect (1)
    // + half bit (8) + 8 data bits + 1 stop bit (16 each) = edge 155.
    e.d = 8'h33; e.pe = 1'b0; e.fe = 1'b0;
    sb.push_back(e);
    fork
      send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        chk("swap_old_word", 32'(dout[0]), 32'h11);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        check_word(0, "swap");
        chk("swap_valid", 32'(dv[0]), 32'd1);
        chk("swap_no_ov", 32'(ov[0]), 32'd0);
      end
    join

    // Reset at the data bit-4 sample point, word 0x33 still pending
    d = 8'hC3;
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx[0] = d[i];
      repeat (c_CPB) @(negedge clk);
    end
    rx[0] = d[4];
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 32'(bz[0]), 32'd1);
    rst   = 1'b0;
    rx[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",  32'(bz[0]),   32'd0);
    chk("mid_rst_valid", 32'(dv[0]),   32'd0);
    chk("mid_rst_data",  32'(dout[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    rdy[0] = 1'b1;
    saw_dv = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dv[0]) saw_dv = 1'b1;
    end
    chk("mid_no_output", 32'(saw_dv), 32'd0);
    recv(0, 8'hC3, 1'b0, 1'b0, 1'b1, "after_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434; clk cycles per UART bit, legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame, legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0; 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1; stop bits checked per frame, 1 or 2.
REQ-005 Port clk, input, 1 bit; single clock, rising edge.
REQ-006 Port rst, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-007 Port uart_rx, input, 1 bit; asynchronous serial line, idle high.
REQ-008 Port data_out, output, DATA_BITS bits; received word, LSB-first on the wire.
REQ-009 Port data_valid, output, 1 bit; data_out holds an unconsumed word.
REQ-010 Port data_ready, input, 1 bit; consumer accepts the word on a clk edge where data_valid && data_ready.
REQ-011 Port parity_err, output, 1 bit; parity mismatch on the word in data_out.
REQ-012 Port frame_err, output, 1 bit; a stop bit of the word in data_out sampled low.
REQ-013 Port overrun_err, output, 1 bit; one-cycle pulse when a completed frame is dropped.
REQ-014 Port busy, output, 1 bit; high whenever the state is not IDLE.

Function
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-016 States: IDLE, START, DATA, PARITY, STOP; a 16-bit clk_count and a bit index are used.
REQ-017 IDLE: rx_s == 0 -> START with clk_count = 0.
REQ-018 START: at clk_count == CLKS_PER_BIT/2 - 1, rx_s == 0 -> DATA, else -> IDLE (false start, no output).
REQ-019 DATA: sample at clk_count == CLKS_PER_BIT - 1, shift in LSB first, clear clk_count; after DATA_BITS samples go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-020 PARITY: sample one bit at CLKS_PER_BIT - 1; error if XOR(data, bit) != 0 for even, or != 1 for odd.
REQ-021 STOP: sample STOP_BITS bits, each at CLKS_PER_BIT - 1; any low sample sets the frame error; after the last sample -> IDLE.
REQ-022 On completion, data_out and both error flags SHALL load and data_valid SHALL assert on the next clk edge.
REQ-023 Latency: data_valid rises 1 clk after the final stop-bit sample point.
REQ-024 A word with frame or parity error SHALL still be delivered, with its flags set.
REQ-025 data_out, parity_err and frame_err SHALL hold stable while data_valid = 1 and no acceptance occurs.
REQ-026 Acceptance with no new completion on the same edge SHALL clear data_valid, parity_err and frame_err.
REQ-027 Completion while data_valid = 1 and data_ready = 0: keep the old word, drop the new frame, pulse overrun_err for 1 clk.
REQ-028 Completion and acceptance on the same edge: load the new word, keep data_valid = 1, no overrun.
REQ-029 All parity and DATA_BITS arithmetic SHALL be width-exact, with no truncation of clk_count compares.

Reset
REQ-030 Asserting rst (low) SHALL force IDLE, clear clk_count, bit index and shift register, set data_out = 0, and set data_valid, parity_err, frame_err, overrun_err and busy = 0.
REQ-031 Asserting rst mid-frame SHALL abandon the frame with no output.
REQ-032 The synchronizer flops SHALL reset to 1 (idle line).

Structure
REQ-033 Package uart_pkg SHALL hold the state enum (IDLE..STOP) and the PARITY_NONE/EVEN/ODD constants.
REQ-034 The synchronizer SHALL be a sub-module uart_rx_sync, 2 flops wide, with asynchronous active-low reset.

Verification
REQ-035 All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=0 and STOP_BITS=1 unless a scenario states otherwise.
REQ-036 Send 0xA5 with data_ready=1 -> data_out=0xA5, data_valid high for 1 clk, all error flags 0.
REQ-037 Low glitch of 4 clks in IDLE -> return to IDLE at the half-bit point, data_valid never asserts.
REQ-038 PARITY_MODE=1: send 0x03 with parity bit 1 -> parity_err=1 and data_out=0x03; send the same word with parity bit 0 -> parity_err=0.
REQ-039 STOP_BITS=2: send 0x5A with the second stop bit low -> frame_err=1 and data_out=0x5A.
REQ-040 Hold data_ready=0 and send 0x11 then 0x22 -> data_out stays 0x11 and overrun_err pulses 1 clk; then raise data_ready on the exact completion edge of 0x33 -> data_out=0x33, no overrun.
REQ-041 Assert rst at the DATA bit-4 sample point -> busy=0 and data_valid=0 next cycle; a subsequent frame 0xC3 is received correctly.
